// File: rtl/reg_bus_arb_if.sv
// One requester port of the register-bus arbiter: a level request with
// held command fields, answered by a single-cycle ack carrying rdata/err.
interface reg_bus_arb_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  modport master (output req, wr, addr, wdata, input  ack, rdata, err);
  modport slave  (input  req, wr, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/reg_bus_arb.sv
// Two-master round-robin arbiter/sequencer for the shared register bus.
// One transaction per grant; out-of-range addresses are answered locally.
module reg_bus_arb #(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    RD_LAT     = 1,
  parameter logic [ADDR_WIDTH-1:0] ADDR_MAX   = 12'h007,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                  clks,
  input  logic                  reset,
  reg_bus_arb_if.slave          m0,
  reg_bus_arb_if.slave          m1,
  output logic                  cpu_wr,
  output logic                  cpu_rd,
  output logic [ADDR_WIDTH-1:0] cpu_wr_addr,
  output logic [DATA_WIDTH-1:0] cpu_data_in,
  input  logic [DATA_WIDTH-1:0] cpu_data_out,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, CMD, WAIT, RESP, REJ} state_t;

  state_t                state, state_nxt;
  logic                  last;      // 1 = m1 served last
  logic                  gnt, gnt_q;
  logic                  any_req;
  logic                  sel_wr, wr_q;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata, wdata_q, rdata_q, resp_data;
  logic [2:0]            cnt;

  // On a tie the master not served last wins; otherwise the sole requester.
  assign any_req   = m0.req | m1.req;
  assign gnt       = (m0.req & m1.req) ? ~last : m1.req;
  assign sel_wr    = gnt ? m1.wr    : m0.wr;
  assign sel_addr  = gnt ? m1.addr  : m0.addr;
  assign sel_wdata = gnt ? m1.wdata : m0.wdata;

  always_ff @(posedge clks or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cpu_wr      = 1'b0;
    cpu_rd      = 1'b0;
    cpu_data_in = '0;
    resp_data   = '0;
    m0.ack      = 1'b0;
    m1.ack      = 1'b0;
    m0.err      = 1'b0;
    m1.err      = 1'b0;
    m0.rdata    = '0;
    m1.rdata    = '0;
    busy        = (state != IDLE);
    case (state)
      IDLE: if (any_req) state_nxt = (sel_addr > ADDR_MAX) ? REJ : CMD;
      CMD: begin
        cpu_wr      = wr_q;
        cpu_rd      = ~wr_q;
        cpu_data_in = wr_q ? wdata_q : '0;
        state_nxt   = wr_q ? RESP : WAIT;
      end
      WAIT: if (cnt == 3'd1) state_nxt = RESP;
      RESP, REJ: begin
        if (!wr_q) resp_data = (state == REJ) ? ERR_DATA : rdata_q;
        m0.ack    = ~gnt_q;
        m1.ack    = gnt_q;
        m0.err    = ~gnt_q & (state == REJ);
        m1.err    = gnt_q & (state == REJ);
        m0.rdata  = gnt_q ? '0 : resp_data;
        m1.rdata  = gnt_q ? resp_data : '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cpu_wr_addr is only loaded for in-range commands so it never shows a
  // rejected address and stays put between CMD and WAIT.
  always_ff @(posedge clks or posedge reset) begin
    if (reset) begin
      last        <= 1'b1;
      gnt_q       <= 1'b0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cnt         <= '0;
      cpu_wr_addr <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          gnt_q   <= gnt;
          wr_q    <= sel_wr;
          wdata_q <= sel_wdata;
          if (sel_addr <= ADDR_MAX) cpu_wr_addr <= sel_addr;
        end
        CMD:  cnt <= 3'(RD_LAT);
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) rdata_q <= cpu_data_out;
        end
        RESP, REJ: last <= gnt_q;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/reg_bus_arb.md
Name: reg_bus_arb

Overview:
Two-master round-robin arbiter and sequencer for the shared user-logic register bus (cpu_wr / cpu_rd / cpu_wr_addr / cpu_data_in / cpu_data_out). It lets the host MPI path (m0) and an internal register sequencer (m1) share the register file. It serialises one transaction per grant and manages the registered read latency. Out-of-range addresses are rejected locally, without a bus cycle.

Parameters:
ADDR_WIDTH, 12, register address width
DATA_WIDTH, 32, register data width
RD_LAT, 1, cycles from cpu_rd assertion until cpu_data_out is valid (1..7)
ADDR_MAX, 12'h007, highest decoded register address; anything above is rejected
ERR_DATA, 32'hDEAD_BEEF, rdata returned for rejected reads

Ports:
clks  in  1  clock
reset  in  1  asynchronous, active-high reset
m0_req / m1_req  in  1  transaction request (level)
m0_wr / m1_wr  in  1  1 = write, 0 = read
m0_addr / m1_addr  in  ADDR_WIDTH  register address
m0_wdata / m1_wdata  in  DATA_WIDTH  write data
m0_ack / m1_ack  out  1  one-cycle completion pulse
m0_rdata / m1_rdata  out  DATA_WIDTH  read data, valid while ack is high
m0_err / m1_err  out  1  address-reject flag, valid while ack is high
cpu_wr  out  1  register write strobe
cpu_rd  out  1  register read strobe
cpu_wr_addr  out  ADDR_WIDTH  shared read/write address
cpu_data_in  out  DATA_WIDTH  register write data
cpu_data_out  in  DATA_WIDTH  registered read data from the register file
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, clks domain):
  - State = IDLE.
  - All outputs = 0.
  - Round-robin pointer = "m1 last served", so m0 wins the first tie.
- Requester rule:
  - Hold req, wr, addr and wdata stable until ack.
  - req is low in the cycle after ack.
  - req is sampled only in IDLE.
- FSM states: IDLE, CMD, WAIT, RESP, REJ.
- IDLE:
  - If any req is high, grant per pointer. One requester → grant it. Both → grant the one not served last.
  - Latch the granted master's wr, addr and wdata into internal registers.
  - Next state: REJ if the latched addr > ADDR_MAX, else CMD.
- CMD (exactly 1 cycle):
  - cpu_wr_addr = latched addr.
  - Write: cpu_wr = 1, cpu_data_in = wdata; next state RESP.
  - Read: cpu_rd = 1; load wait counter = RD_LAT; next state WAIT.
- WAIT:
  - cpu_wr_addr stays at the latched addr; cpu_rd = 0.
  - Counter decrements each cycle.
  - In the cycle the counter reaches 1, capture cpu_data_out into the rdata register and go to RESP.
- RESP (1 cycle):
  - Granted master's ack = 1 and err = 0.
  - rdata = captured value for reads, 0 for writes.
  - Pointer updates to the granted master. Next state IDLE.
- REJ (1 cycle):
  - No cpu_wr or cpu_rd pulse.
  - ack = 1, err = 1, rdata = ERR_DATA for reads or 0 for writes.
  - Pointer updates. Next state IDLE.
- Bus outputs when not driven: cpu_wr, cpu_rd, cpu_data_in = 0. cpu_wr_addr holds its last value (no glitch to 0 between CMD and WAIT).
- The non-granted ack, rdata and err are always 0.
- Latency, from the IDLE cycle t0 that samples req:
  - Write: cpu_wr at t0+1, ack at t0+2.
  - Read: cpu_rd at t0+1, ack at t0+2+RD_LAT.
  - Reject: ack at t0+1.
- Fairness: with both requesters continuously active, grants strictly alternate. Worst-case wait is one transaction.
- A req rising during CMD, WAIT or RESP is held off until the next IDLE; it is never lost.
- Reset during CMD or WAIT aborts the transaction: no ack, bus strobes drop immediately.
- cpu_wr and cpu_rd are never high in the same cycle, and each is never high for more than 1 cycle per transaction.

Test Plan:
- Reset, then m0 write addr 0x002 data 0x0000_0005 → cpu_wr single pulse at t0+1 with addr 0x002 and data 5; m0_ack at t0+2, m0_err = 0.
- m0 writes 3 to 0x003, then reads 0x004 after the adder settles → m0_rdata = 0x0000_0008 with ack at t0+3 (RD_LAT = 1).
- m0 and m1 both request reads of 0x000 on the same cycle after reset → m0 served first, rdata 0x2017_1208; m1 served next, same data; grant order m0, m1, m0, m1 under continuous requests.
- m1 reads 0x123 → no cpu_rd pulse, m1_ack at t0+1 with m1_err = 1 and rdata 0xDEAD_BEEF; the following m0 read of 0x001 returns 0x00D1_0006.
- Reset asserted while in WAIT → cpu_rd and cpu_wr = 0 and no ack; after release, a new m1 request is served with normal latency.
- RD_LAT = 3 build, read 0x006 after writing 0x00AA → cpu_wr_addr held at 0x006 for 4 cycles, ack at t0+5, rdata 0x0000_00AA.
